// File: rtl/ctrl_link_pkg.sv
// Shared constants and types for the control-link master: comma symbol,
// completion status codes, FSM states and header bit layout.
package ctrl_link_pkg;

  localparam logic [7:0] COMMA = 8'hBC;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_REMOTE_ERR = 2'd1,
    ST_TIMEOUT    = 2'd2,
    ST_LINK_DOWN  = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  // TX header is {seq, 2'b00, write, valid}; RX header is {seq, 2'b00, err, ack}
  localparam int HDR_VALID_BIT = 0;
  localparam int HDR_WRITE_BIT = 1;
  localparam int HDR_ACK_BIT   = 0;
  localparam int HDR_ERR_BIT   = 1;
  localparam int HDR_SEQ_LSB   = 4;

  function automatic logic [7:0] txHeader(input logic [3:0] seq, input logic write,
                                          input logic valid);
    logic [7:0] h;
    h = 8'h00;
    h[HDR_SEQ_LSB +: 4] = seq;
    h[HDR_WRITE_BIT]    = write;
    h[HDR_VALID_BIT]    = valid;
    return h;
  endfunction

endpackage

// File: rtl/ctrl_link_rx_deframer.sv
// Reassembles response frames (comma, header, data LSB-first) from the decoder
// byte stream and reports each complete frame with a one-cycle frameValid_o.
module ctrl_link_rx_deframer
  import ctrl_link_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rxValid_i,
  input  logic [7:0]        rxByte_i,
  input  logic              rxK_i,
  input  logic              linkOk_i,
  output logic              frameValid_o,
  output logic [3:0]        frameSeq_o,
  output logic              frameAck_o,
  output logic              frameErr_o,
  output logic [DATA_W-1:0] frameData_o
);

  localparam int DB = DATA_W / 8;
  localparam int NR = 2 + DB;
  localparam int CW = $clog2(NR);
  localparam logic [CW-1:0] CNT_LAST = CW'(NR - 1);

  logic [CW-1:0]     cnt_q;
  logic [3:0]        seq_q;
  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] payload_q;
  logic [DATA_W-1:0] payloadNext;
  logic              frameValid_q;
  logic [3:0]        frameSeq_q;
  logic              frameAck_q;
  logic              frameErr_q;
  logic [DATA_W-1:0] frameData_q;

  always_comb begin
    payloadNext = payload_q;
    for (int i = 0; i < DB; i++) begin
      if (cnt_q == CW'(i + 2)) payloadNext[i*8 +: 8] = rxByte_i;
    end
  end

  // cnt_q == 0 means hunting for a comma; any comma restarts a frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      seq_q        <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      payload_q    <= '0;
      frameValid_q <= 1'b0;
      frameSeq_q   <= '0;
      frameAck_q   <= 1'b0;
      frameErr_q   <= 1'b0;
      frameData_q  <= '0;
    end else begin
      frameValid_q <= 1'b0;
      if (!linkOk_i) begin
        cnt_q <= '0;
      end else if (rxValid_i) begin
        if (rxK_i) begin
          cnt_q <= (rxByte_i == COMMA) ? CW'(1) : '0;
        end else if (cnt_q == CW'(1)) begin
          seq_q <= rxByte_i[HDR_SEQ_LSB +: 4];
          ack_q <= rxByte_i[HDR_ACK_BIT];
          err_q <= rxByte_i[HDR_ERR_BIT];
          cnt_q <= CW'(2);
        end else if (cnt_q >= CW'(2)) begin
          payload_q <= payloadNext;
          if (cnt_q == CNT_LAST) begin
            frameValid_q <= 1'b1;
            frameSeq_q   <= seq_q;
            frameAck_q   <= ack_q;
            frameErr_q   <= err_q;
            frameData_q  <= payloadNext;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end
  end

  assign frameValid_o = frameValid_q;
  assign frameSeq_o   = frameSeq_q;
  assign frameAck_o   = frameAck_q;
  assign frameErr_o   = frameErr_q;
  assign frameData_o  = frameData_q;

endmodule

// File: rtl/ctrl_link_master_p.sv
// Control-link master: turns one request at a time into a repeating TX frame,
// waits for a matching RX response with timeout/retry, and reports a status.
module ctrl_link_master_p
  import ctrl_link_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_status,
  output logic              busy,
  input  logic              tx_en,
  output logic [7:0]        tx_byte,
  output logic              tx_k,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_k,
  input  logic              link_ok
);

  localparam int AB = ADDR_W / 8;
  localparam int DB = DATA_W / 8;
  localparam int NT = 2 + AB + DB;
  localparam int PW = $clog2(NT);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NT - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  state_e            state_q;
  logic [3:0]        seq_q;
  logic [TW-1:0]     timer_q;
  logic [RW-1:0]     retry_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              respValid_q;
  logic [DATA_W-1:0] respRdata_q;
  status_e           respStatus_q;

  logic [PW-1:0]     txPtr_q;
  logic [7:0]        txByte_q, txByte_d;
  logic              txK_q, txK_d;
  logic [7:0]        snapHdr_q;
  logic [ADDR_W-1:0] snapAddr_q;
  logic [DATA_W-1:0] snapData_q;

  logic              frameValid;
  logic [3:0]        frameSeq;
  logic              frameAck;
  logic              frameErr;
  logic [DATA_W-1:0] frameData;

  ctrl_link_rx_deframer #(.DATA_W(DATA_W)) uDeframer (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .rxValid_i    (rx_valid),
    .rxByte_i     (rx_byte),
    .rxK_i        (rx_k),
    .linkOk_i     (link_ok),
    .frameValid_o (frameValid),
    .frameSeq_o   (frameSeq),
    .frameAck_o   (frameAck),
    .frameErr_o   (frameErr),
    .frameData_o  (frameData)
  );

  // Priority in ACTIVE: link loss, then matching response, then timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      seq_q        <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      respValid_q  <= 1'b0;
      respRdata_q  <= '0;
      respStatus_q <= ST_OK;
    end else begin
      respValid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            seq_q   <= seq_q + 4'd1;
            timer_q <= '0;
            retry_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!link_ok) begin
            state_q      <= COMPLETE;
            respValid_q  <= 1'b1;
            respStatus_q <= ST_LINK_DOWN;
            respRdata_q  <= '0;
          end else if (frameValid && frameAck && (frameSeq == seq_q)) begin
            state_q      <= COMPLETE;
            respValid_q  <= 1'b1;
            respStatus_q <= frameErr ? ST_REMOTE_ERR : ST_OK;
            respRdata_q  <= write_q ? '0 : frameData;
          end else if (timer_q == TIMER_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + RW'(1);
              timer_q <= '0;
            end else begin
              state_q      <= COMPLETE;
              respValid_q  <= 1'b1;
              respStatus_q <= ST_TIMEOUT;
              respRdata_q  <= '0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        COMPLETE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    txByte_d = 8'h00;
    txK_d    = 1'b0;
    if (txPtr_q == '0) begin
      txByte_d = COMMA;
      txK_d    = 1'b1;
    end else if (txPtr_q == PW'(1)) begin
      txByte_d = snapHdr_q;
    end
    for (int i = 0; i < AB; i++) begin
      if (txPtr_q == PW'(2 + i)) txByte_d = snapAddr_q[i*8 +: 8];
    end
    for (int i = 0; i < DB; i++) begin
      if (txPtr_q == PW'(2 + AB + i)) txByte_d = snapData_q[i*8 +: 8];
    end
  end

  // Frame content is sampled only while the comma goes out, so a frame
  // never carries a mix of two requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txPtr_q    <= '0;
      txByte_q   <= 8'h00;
      txK_q      <= 1'b0;
      snapHdr_q  <= 8'h00;
      snapAddr_q <= '0;
      snapData_q <= '0;
    end else if (tx_en) begin
      txByte_q <= txByte_d;
      txK_q    <= txK_d;
      txPtr_q  <= (txPtr_q == PTR_LAST) ? '0 : txPtr_q + PW'(1);
      if (txPtr_q == '0) begin
        if (state_q == ACTIVE) begin
          snapHdr_q  <= txHeader(seq_q, write_q, 1'b1);
          snapAddr_q <= addr_q;
          snapData_q <= wdata_q;
        end else begin
          snapHdr_q  <= 8'h00;
          snapAddr_q <= '0;
          snapData_q <= '0;
        end
      end
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign resp_valid  = respValid_q;
  assign resp_rdata  = respRdata_q;
  assign resp_status = respStatus_q;
  assign tx_byte     = txByte_q;
  assign tx_k        = txK_q;

endmodule

// File: tb/tb_ctrl_link_master_p.sv
// Directed bench for ctrl_link_master_p: table of request/response vectors plus
// hand-written sequences for TX framing, stale/partial frames, timeout, link loss, reset.
module tb_ctrl_link_master_p;
  import ctrl_link_pkg::*;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;
  localparam int MAX_RETRY   = 3;
  localparam int NT          = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_status;
  logic        busy;
  logic        tx_en, tx_k;
  logic [7:0]  tx_byte;
  logic        rx_valid, rx_k, link_ok;
  logic [7:0]  rx_byte;

  int checkCount = 0;
  int passCount  = 0;
  logic [3:0] expSeq = 4'd0;

  logic [7:0]    txFrame [NT];
  logic [NT-1:0] txKVec;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rxData;
    logic [1:0]  expStatus;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [5];

  ctrl_link_master_p #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_status(resp_status),
    .busy(busy),
    .tx_en(tx_en), .tx_byte(tx_byte), .tx_k(tx_k),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_k(rx_k), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  // Hard stop in case some sequence wedges despite the per-wait bounds
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [7:0] rxHdr(input logic [3:0] seq, input logic err, input logic ack);
    return {seq, 2'b00, err, ack};
  endfunction

  task automatic issueRequest(input logic w, input logic [15:0] a, input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready_before_request", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    expSeq    = expSeq + 4'd1;
  endtask

  task automatic sendRxFrame(input logic [7:0] hdr, input logic [31:0] data);
    rx_valid = 1'b1;
    rx_k     = 1'b1;
    rx_byte  = 8'hBC;
    @(negedge clk);
    rx_k    = 1'b0;
    rx_byte = hdr;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_byte = data[i*8 +: 8];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic waitResp(input int maxCycles, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < maxCycles) begin
      @(negedge clk);
      cycles++;
      if (resp_valid) seen = 1'b1;
    end
  endtask

  task automatic captureTxFrame(output bit found);
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (tx_k) begin
        txFrame[0] = tx_byte;
        txKVec[0]  = tx_k;
        for (int i = 1; i < NT; i++) begin
          @(negedge clk);
          txFrame[i] = tx_byte;
          txKVec[i]  = tx_k;
        end
        found = txFrame[1][0];
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int cyc;
    bit seen;
    issueRequest(v.write, v.addr, v.wdata);
    checkOutput($sformatf("vec%0d_busy", idx), busy, 1);
    sendRxFrame(rxHdr(expSeq, v.err, v.ack), v.rxData);
    waitResp(100, cyc, seen);
    checkOutput($sformatf("vec%0d_resp_seen", idx), seen, 1);
    if (seen) begin
      checkOutput($sformatf("vec%0d_status", idx), resp_status, v.expStatus);
      checkOutput($sformatf("vec%0d_rdata", idx), resp_rdata, v.expRdata);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_resp_pulse", idx), resp_valid, 0);
    end
  endtask

  initial begin
    logic [7:0] expFrame [NT];
    int cyc;
    int cnt;
    int hdrBad;
    bit seen, found, late, prevK;

    vecs[0] = '{1'b1, 16'h1234, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0BAD0BAD, 2'd0, 32'h0};
    vecs[1] = '{1'b0, 16'h0040, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D, 2'd0, 32'hCAFEF00D};
    vecs[2] = '{1'b0, 16'h0100, 32'h0,        1'b1, 1'b1, 32'h11223344, 2'd1, 32'h11223344};
    vecs[3] = '{1'b1, 16'hFFFF, 32'h01020304, 1'b1, 1'b1, 32'h55667788, 2'd1, 32'h0};
    vecs[4] = '{1'b0, 16'h00AA, 32'h0,        1'b0, 1'b0, 32'h99999999, 2'd2, 32'h0};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    tx_en     = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    rx_k      = 1'b0;
    link_ok   = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_resp_valid", resp_valid, 0);
    checkOutput("reset_tx_byte", tx_byte, 8'h00);
    checkOutput("reset_tx_k", tx_k, 0);
    checkOutput("reset_resp_status", resp_status, 0);
    checkOutput("reset_resp_rdata", resp_rdata, 0);

    reset_n = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", req_ready, 0);
    @(negedge clk);
    checkOutput("ready_after_first_edge", req_ready, 1);

    repeat (2) @(negedge clk);
    checkOutput("tx_hold_without_en", {tx_k, tx_byte}, 9'h000);
    tx_en = 1'b1;
    @(negedge clk);
    checkOutput("tx_first_comma", {tx_k, tx_byte}, 9'h1BC);
    @(negedge clk);
    checkOutput("tx_idle_header", {tx_k, tx_byte}, 9'h000);

    // Write 0x1234/0xDEADBEEF: seq 1 write header is 0x13
    issueRequest(1'b1, 16'h1234, 32'hDEADBEEF);
    expFrame = '{8'hBC, 8'h13, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int rep = 0; rep < 2; rep++) begin
      captureTxFrame(found);
      checkOutput($sformatf("wr_frame%0d_found", rep), found, 1);
      for (int i = 0; i < NT; i++)
        checkOutput($sformatf("wr_frame%0d_byte%0d", rep, i), txFrame[i], expFrame[i]);
      checkOutput($sformatf("wr_frame%0d_kbits", rep), txKVec, 8'h01);
    end
    sendRxFrame(8'h11, 32'h0);
    waitResp(20, cyc, seen);
    checkOutput("wr_resp_seen", seen, 1);
    checkOutput("wr_resp_status", resp_status, 0);
    checkOutput("wr_resp_rdata", resp_rdata, 0);

    // Read with a stale seq-1 response ahead of the real seq-2 response
    issueRequest(1'b0, 16'h0040, 32'h0);
    sendRxFrame(8'h11, 32'h12345678);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    checkOutput("stale_ignored", cnt, 0);
    sendRxFrame(8'h21, 32'hCAFEF00D);
    waitResp(20, cyc, seen);
    checkOutput("rd_resp_seen", seen, 1);
    checkOutput("rd_resp_status", resp_status, 0);
    checkOutput("rd_resp_rdata", resp_rdata, 32'hCAFEF00D);

    // No response at all: four attempts of 16 cycles, seq held across retries
    issueRequest(1'b0, 16'h0200, 32'h0);
    hdrBad = 0;
    late   = 1'b0;
    prevK  = tx_k;
    cyc    = 0;
    seen   = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (prevK && tx_byte[0]) begin
        if (k > 20) late = 1'b1;
        if (tx_byte != {expSeq, 2'b00, 1'b0, 1'b1}) hdrBad++;
      end
      prevK = tx_k;
      if (resp_valid) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
    checkOutput("to_latency", cyc, 64);
    checkOutput("to_status", resp_status, 2);
    checkOutput("to_rdata", resp_rdata, 0);
    checkOutput("to_seq_stable", hdrBad, 0);
    checkOutput("to_header_after_retry", late, 1);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // link_ok drops in the same cycle the matching frame reaches the FSM
    issueRequest(1'b0, 16'h0300, 32'h0);
    sendRxFrame(rxHdr(expSeq, 1'b0, 1'b1), 32'hA5A5A5A5);
    link_ok = 1'b0;
    @(negedge clk);
    checkOutput("ld_resp_valid", resp_valid, 1);
    checkOutput("ld_status", resp_status, 3);
    checkOutput("ld_rdata", resp_rdata, 0);
    link_ok = 1'b1;
    @(negedge clk);
    checkOutput("ld_resp_pulse", resp_valid, 0);

    // Early comma after three bytes restarts the frame
    issueRequest(1'b0, 16'h0500, 32'h0);
    rx_valid = 1'b1;
    rx_k     = 1'b1;
    rx_byte  = 8'hBC;
    @(negedge clk);
    rx_k    = 1'b0;
    rx_byte = rxHdr(expSeq, 1'b0, 1'b1);
    @(negedge clk);
    rx_byte = 8'h77;
    @(negedge clk);
    sendRxFrame(rxHdr(expSeq, 1'b0, 1'b1), 32'h0BADF00D);
    waitResp(20, cyc, seen);
    checkOutput("partial_resp_seen", seen, 1);
    checkOutput("partial_resp_latency", cyc, 1);
    checkOutput("partial_rdata", resp_rdata, 32'h0BADF00D);

    // Reset in the middle of an active request
    issueRequest(1'b0, 16'h0600, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_ready", req_ready, 0);
    checkOutput("mid_reset_busy", busy, 0);
    checkOutput("mid_reset_resp_valid", resp_valid, 0);
    checkOutput("mid_reset_tx", {tx_k, tx_byte}, 9'h000);
    checkOutput("mid_reset_rdata", resp_rdata, 0);
    checkOutput("mid_reset_status", resp_status, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expSeq  = 4'd0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    checkOutput("no_resp_after_reset", cnt, 0);

    // Sixteen quick LINK_DOWN completions wrap seq, so the 17th uses seq 1
    link_ok = 1'b0;
    cnt = 0;
    for (int r = 0; r < 16; r++) begin
      issueRequest(1'b0, 16'h0700, 32'h0);
      waitResp(10, cyc, seen);
      if (!seen || resp_status != 2'd3) cnt++;
    end
    checkOutput("wrap_link_down_runs", cnt, 0);
    link_ok = 1'b1;
    @(negedge clk);
    issueRequest(1'b0, 16'h0700, 32'h0);
    captureTxFrame(found);
    checkOutput("wrap_frame_found", found, 1);
    checkOutput("wrap_header_seq1", txFrame[1], 8'h11);
    sendRxFrame(8'h11, 32'h600D600D);
    waitResp(20, cyc, seen);
    checkOutput("wrap_resp_seen", seen, 1);
    checkOutput("wrap_status", resp_status, 0);
    checkOutput("wrap_rdata", resp_rdata, 32'h600D600D);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
